// File: rtl/pipe_control.sv
// Pipelined RISC-I control: ID decode, ID/EX-EX/MEM-MEM/WB control
// registers, load-use hazard detection and a saturating stall counter.
module pipe_control #(
  parameter int OP_W       = 6,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 3,
  parameter int ENABLE_IMM = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [OP_W-1:0]       i_OP,
  input  logic [REG_ADDR_W-1:0] i_Rs,
  input  logic [REG_ADDR_W-1:0] i_Rt,
  input  logic                  i_Flush,
  output logic                  o_Stall,
  output logic                  o_ID_Jump,
  output logic                  o_EX_RegDst,
  output logic                  o_EX_ALUSrc,
  output logic [ALUOP_W-1:0]    o_EX_ALUop,
  output logic                  o_EX_Illegal,
  output logic                  o_MEM_Branch,
  output logic                  o_MEM_NotEqualBranch,
  output logic                  o_MEM_MemRead,
  output logic                  o_MEM_MemWrite,
  output logic                  o_WB_RegWrite,
  output logic                  o_WB_MemtoReg,
  output logic [CNT_W-1:0]      o_StallCnt
);

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'b001010);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b001101);

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_R   = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_J   = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'b101);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'b110);

  typedef struct packed {
    logic               reg_dst;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               illegal;
    logic               branch;
    logic               bne;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               mem_to_reg;
  } id_ex_t;

  typedef struct packed {
    logic branch;
    logic bne;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } ex_mem_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } mem_wb_t;

  id_ex_t                  dec;
  logic                    jump;
  logic                    imm;
  id_ex_t                  idex_d, idex_q;
  logic [REG_ADDR_W-1:0]   rt_d, rt_q;
  ex_mem_t                 exmem_q;
  mem_wb_t                 memwb_q;
  logic [CNT_W-1:0]        cnt_d, cnt_q;
  logic                    stall;

  always_comb begin
    dec  = '0;
    jump = 1'b0;
    imm  = 1'b0;
    unique case (i_OP)
      OP_R: begin
        dec.reg_dst   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_R;
      end
      OP_J: begin
        jump       = 1'b1;
        dec.alu_op = ALU_J;
      end
      OP_BEQ: begin
        dec.branch = 1'b1;
        dec.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        dec.bne    = 1'b1;
        dec.alu_op = ALU_SUB;
      end
      OP_LW: begin
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_op    = ALU_ADD;
      end
      OP_ADDI: begin imm = 1'b1; dec.alu_op = ALU_ADD; end
      OP_SLTI: begin imm = 1'b1; dec.alu_op = ALU_SLT; end
      OP_ANDI: begin imm = 1'b1; dec.alu_op = ALU_AND; end
      OP_ORI:  begin imm = 1'b1; dec.alu_op = ALU_OR;  end
      default: dec.illegal = 1'b1;
    endcase
    // Immediate ops collapse to a plain illegal when the build omits them
    if (imm) begin
      if (ENABLE_IMM != 0) begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end else begin
        dec         = '0;
        dec.illegal = 1'b1;
      end
    end
  end

  assign stall = idex_q.mem_read && (rt_q != '0) &&
                 ((rt_q == i_Rs) || (rt_q == i_Rt));

  always_comb begin
    idex_d = dec;
    rt_d   = i_Rt;
    cnt_d  = cnt_q;
    if (i_Flush || stall) begin
      idex_d = '0;
      rt_d   = '0;
    end
    if (stall && !i_Flush && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      idex_q  <= '0;
      rt_q    <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      cnt_q   <= '0;
    end else begin
      idex_q  <= idex_d;
      rt_q    <= rt_d;
      exmem_q <= '{branch:     idex_q.branch,
                   bne:        idex_q.bne,
                   mem_read:   idex_q.mem_read,
                   mem_write:  idex_q.mem_write,
                   reg_write:  idex_q.reg_write,
                   mem_to_reg: idex_q.mem_to_reg};
      memwb_q <= '{reg_write:  exmem_q.reg_write,
                   mem_to_reg: exmem_q.mem_to_reg};
      cnt_q   <= cnt_d;
    end
  end

  assign o_Stall              = stall;
  assign o_ID_Jump            = jump & ~stall;
  assign o_EX_RegDst          = idex_q.reg_dst;
  assign o_EX_ALUSrc          = idex_q.alu_src;
  assign o_EX_ALUop           = idex_q.alu_op;
  assign o_EX_Illegal         = idex_q.illegal;
  assign o_MEM_Branch         = exmem_q.branch;
  assign o_MEM_NotEqualBranch = exmem_q.bne;
  assign o_MEM_MemRead        = exmem_q.mem_read;
  assign o_MEM_MemWrite       = exmem_q.mem_write;
  assign o_WB_RegWrite        = memwb_q.reg_write;
  assign o_WB_MemtoReg        = memwb_q.mem_to_reg;
  assign o_StallCnt           = cnt_q;

endmodule

// File: tb/tb_pipe_control.sv
// Scoreboard bench for pipe_control: default, no-immediate and
// 2-bit-counter builds driven with the same instruction stream.
module tb_pipe_control;

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] SLTI = 6'b001010;
  localparam logic [5:0] ANDI = 6'b001100;
  localparam logic [5:0] ORI  = 6'b001101;
  localparam logic [5:0] BAD  = 6'b111111;
  localparam logic [5:0] BAD2 = 6'b000111;

  typedef struct packed {
    logic rd, as;
    logic [2:0] aop;
    logic ill, br, bne, mr, mw, rw, m2r, j;
  } rec_t;

  typedef struct packed {
    rec_t a;
    rec_t b;
  } pair_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] op;
  logic [4:0] rs, rt;
  logic flush;

  wire st0, st1, st2, j0, j1, j2;
  wire [5:0] ex0, ex1, ex2;
  wire [3:0] mem0, mem1, mem2;
  wire [1:0] wb0, wb1, wb2;
  wire [15:0] c0, c1;
  wire [1:0] c2;

  pair_t sb[$];
  logic [4:0] m_rt;
  int m_cnt, m_cnt2;
  int n_vec = 0;
  int n_err = 0;
  bit warm = 1'b0;

  always #5 clk = ~clk;

  pipe_control u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_OP(op), .i_Rs(rs), .i_Rt(rt),
    .i_Flush(flush), .o_Stall(st0), .o_ID_Jump(j0),
    .o_EX_RegDst(ex0[5]), .o_EX_ALUSrc(ex0[4]),
    .o_EX_ALUop(ex0[3:1]), .o_EX_Illegal(ex0[0]),
    .o_MEM_Branch(mem0[3]), .o_MEM_NotEqualBranch(mem0[2]),
    .o_MEM_MemRead(mem0[1]), .o_MEM_MemWrite(mem0[0]),
    .o_WB_RegWrite(wb0[1]), .o_WB_MemtoReg(wb0[0]),
    .o_StallCnt(c0));

  pipe_control #(.ENABLE_IMM(0)) u_noimm (
    .i_clk(clk), .i_rst_n(rst_n), .i_OP(op), .i_Rs(rs), .i_Rt(rt),
    .i_Flush(flush), .o_Stall(st1), .o_ID_Jump(j1),
    .o_EX_RegDst(ex1[5]), .o_EX_ALUSrc(ex1[4]),
    .o_EX_ALUop(ex1[3:1]), .o_EX_Illegal(ex1[0]),
    .o_MEM_Branch(mem1[3]), .o_MEM_NotEqualBranch(mem1[2]),
    .o_MEM_MemRead(mem1[1]), .o_MEM_MemWrite(mem1[0]),
    .o_WB_RegWrite(wb1[1]), .o_WB_MemtoReg(wb1[0]),
    .o_StallCnt(c1));

  pipe_control #(.CNT_W(2)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_OP(op), .i_Rs(rs), .i_Rt(rt),
    .i_Flush(flush), .o_Stall(st2), .o_ID_Jump(j2),
    .o_EX_RegDst(ex2[5]), .o_EX_ALUSrc(ex2[4]),
    .o_EX_ALUop(ex2[3:1]), .o_EX_Illegal(ex2[0]),
    .o_MEM_Branch(mem2[3]), .o_MEM_NotEqualBranch(mem2[2]),
    .o_MEM_MemRead(mem2[1]), .o_MEM_MemWrite(mem2[0]),
    .o_WB_RegWrite(wb2[1]), .o_WB_MemtoReg(wb2[0]),
    .o_StallCnt(c2));

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  function automatic rec_t dec(input logic [5:0] o, input bit imm);
    rec_t r = '0;
    case (o)
      R:    begin r.rd = 1; r.rw = 1; r.aop = 3'b010; end
      J:    begin r.j = 1; r.aop = 3'b011; end
      BEQ:  begin r.br = 1; r.aop = 3'b001; end
      BNE:  begin r.bne = 1; r.aop = 3'b001; end
      LW:   begin r.as = 1; r.mr = 1; r.m2r = 1; r.rw = 1; end
      SW:   begin r.as = 1; r.mw = 1; end
      ADDI: begin r.as = imm; r.rw = imm; r.ill = !imm; end
      SLTI: begin r.as = imm; r.rw = imm; r.ill = !imm;
                  r.aop = imm ? 3'b100 : 3'b000; end
      ANDI: begin r.as = imm; r.rw = imm; r.ill = !imm;
                  r.aop = imm ? 3'b101 : 3'b000; end
      ORI:  begin r.as = imm; r.rw = imm; r.ill = !imm;
                  r.aop = imm ? 3'b110 : 3'b000; end
      default: r.ill = 1;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] exv(input rec_t r);
    return 32'({r.rd, r.as, r.aop, r.ill});
  endfunction

  function automatic logic [31:0] memv(input rec_t r);
    return 32'({r.br, r.bne, r.mr, r.mw});
  endfunction

  function automatic logic [31:0] wbv(input rec_t r);
    return 32'({r.rw, r.m2r});
  endfunction

  task automatic cyc(input logic [5:0] o, input logic [4:0] s,
                     input logic [4:0] t, input logic fl, input logic rn);
    rec_t da, db;
    pair_t p;
    logic st;
    op = o; rs = s; rt = t; flush = fl; rst_n = rn;
    #1;
    st = sb[2].a.mr && (m_rt != 0) && (m_rt == s || m_rt == t);
    da = dec(o, 1'b1);
    db = dec(o, 1'b0);
    if (warm) begin
      check("stall", 32'(st0), 32'(st));
      check("stall_noimm", 32'(st1), 32'(st));
      check("stall_sat", 32'(st2), 32'(st));
      check("jump", 32'(j0), 32'(da.j && !st));
      check("jump_noimm", 32'(j1), 32'(db.j && !st));
    end
    if (!rn) begin
      sb = {};
      repeat (3) sb.push_back('0);
      m_rt = '0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      if (st && !fl) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      p.a = (fl || st) ? '0 : da;
      p.b = (fl || st) ? '0 : db;
      m_rt = (fl || st) ? 5'd0 : t;
      sb.push_back(p);
      void'(sb.pop_front());
    end
    @(posedge clk);
    #1;
    check("ex", 32'(ex0), exv(sb[2].a));
    check("ex_noimm", 32'(ex1), exv(sb[2].b));
    check("ex_sat", 32'(ex2), exv(sb[2].a));
    check("mem", 32'(mem0), memv(sb[1].a));
    check("mem_noimm", 32'(mem1), memv(sb[1].b));
    check("wb", 32'(wb0), wbv(sb[0].a));
    check("wb_noimm", 32'(wb1), wbv(sb[0].b));
    check("cnt", 32'(c0), 32'(m_cnt));
    check("cnt_noimm", 32'(c1), 32'(m_cnt));
    check("cnt_sat", 32'(c2), 32'(m_cnt2));
    warm = 1'b1;
    @(negedge clk);
  endtask

  task automatic nops(input int n);
    repeat (n) cyc(R, 5'd0, 5'd0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [5:0] ops [12];
    ops = '{R, J, BEQ, BNE, LW, SW, ADDI, SLTI, ANDI, ORI, BAD, BAD2};
    repeat (3) sb.push_back('0);
    m_rt = '0; m_cnt = 0; m_cnt2 = 0;
    @(negedge clk);
    cyc(R, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc(R, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc(R, 5'd1, 5'd2, 1'b0, 1'b1);
    nops(3);
    // load-use on rs, then rt=0 load that must not stall
    cyc(LW, 5'd1, 5'd5, 1'b0, 1'b1);
    cyc(R, 5'd5, 5'd6, 1'b0, 1'b1);
    cyc(R, 5'd5, 5'd6, 1'b0, 1'b1);
    nops(3);
    cyc(LW, 5'd1, 5'd0, 1'b0, 1'b1);
    cyc(R, 5'd0, 5'd0, 1'b0, 1'b1);
    nops(2);
    // back-to-back dependent loads
    cyc(LW, 5'd1, 5'd5, 1'b0, 1'b1);
    cyc(LW, 5'd5, 5'd7, 1'b0, 1'b1);
    cyc(LW, 5'd5, 5'd7, 1'b0, 1'b1);
    cyc(R, 5'd2, 5'd7, 1'b0, 1'b1);
    cyc(R, 5'd2, 5'd7, 1'b0, 1'b1);
    nops(3);
    // flush alone, then flush coinciding with a stall
    cyc(BEQ, 5'd1, 5'd2, 1'b1, 1'b1);
    nops(3);
    cyc(LW, 5'd1, 5'd3, 1'b0, 1'b1);
    cyc(R, 5'd3, 5'd4, 1'b1, 1'b1);
    nops(3);
    foreach (ops[i]) cyc(ops[i], 5'd1, 5'd2, 1'b0, 1'b1);
    nops(3);
    // five stalls to saturate the 2-bit counter
    repeat (5) begin
      cyc(LW, 5'd0, 5'd4, 1'b0, 1'b1);
      cyc(SW, 5'd4, 5'd1, 1'b0, 1'b1);
      cyc(SW, 5'd4, 5'd1, 1'b0, 1'b1);
    end
    // reset mid-pipeline with a stall pending
    cyc(LW, 5'd1, 5'd6, 1'b0, 1'b1);
    cyc(R, 5'd6, 5'd1, 1'b0, 1'b0);
    nops(3);
    repeat (300) begin
      cyc(ops[$urandom_range(0, 11)], 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), $urandom_range(0, 7) == 0,
          $urandom_range(0, 59) != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
